// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding and sizing helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pll_ctrl_pkg;

    localparam int STATE_W = 3;

    // Encoding is visible on the debug state output, so the values are fixed.
    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_t;

    // Bits needed for a counter that runs 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Bundle between the lock sequencer and the PLL / reset tree.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
// Ports: pll_locked, fault_clr into the sequencer; pll_rst, sys_rst,
// lock_lost, fault, retry_cnt, state out of it.
interface pll_lock_sequencer_if #(
    parameter int MAX_RETRIES = 3
);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    logic                             pll_locked;
    logic                             fault_clr;
    logic                             pll_rst;
    logic                             sys_rst;
    logic                             lock_lost;
    logic                             fault;
    logic [RETRY_W-1:0]               retry_cnt;
    logic [pll_ctrl_pkg::STATE_W-1:0] state;

    // master: the sequencer itself
    modport master (
        input  pll_locked, fault_clr,
        output pll_rst, sys_rst, lock_lost, fault, retry_cnt, state
    );

    // slave: PLL, reset tree and supervisor software side
    modport slave (
        output pll_locked, fault_clr,
        input  pll_rst, sys_rst, lock_lost, fault, retry_cnt, state
    );

endinterface

// File: rtl/pll_lock_sequencer_sync.sv
// Two-flop synchronizer for a single asynchronous level into the local clock.
// Latency: two clock edges from input change to o_q.
// Backpressure: none.
// Ports: i_clk, i_rst (sync, active-high, clears both flops), i_d async in, o_q synced out.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up/supervision: pulses PLL reset, qualifies lock, releases system reset, retries then faults.
// Latency: all outputs registered, updating on the same edge as the state register.
// Backpressure: none; fault_clr is a single-cycle request honoured only in FAULT.
// Ports: i_refclk (only clock), i_rst (sync, active-high), pll_if (master modport).
module pll_lock_sequencer
    import pll_ctrl_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 50,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                 i_refclk,
    input  logic                 i_rst,
    pll_lock_sequencer_if.master pll_if
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int TIMER_W = cnt_w(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    localparam logic [TIMER_W-1:0] PLL_RST_LAST = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    pll_state_t         r_state;
    pll_state_t         w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               w_lock_lost_nxt;
    logic               w_locked_s;
    logic               w_timer_run;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_lock_lost;
    logic               r_fault;

    sync_2ff u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (pll_if.pll_locked),
        .o_q   (w_locked_s)
    );

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state <= ST_PLL_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_retry_nxt     = r_retry_cnt;
        w_lock_lost_nxt = 1'b0;
        case (r_state)
            ST_PLL_RST: begin
                if (r_timer == PLL_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock is checked first so it wins over a coincident timeout.
                if (w_locked_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_timer == TIMEOUT_LAST) begin
                    if (r_retry_cnt == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_state_nxt = ST_PLL_RST;
                        w_retry_nxt = r_retry_cnt + RETRY_W'(1);
                    end
                end
            end
            ST_STABLE: begin
                // A dropout is treated as a glitch: re-wait without counting a retry.
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_timer == STABLE_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_retry_nxt = '0;
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt     = ST_PLL_RST;
                    w_lock_lost_nxt = 1'b1;
                end
            end
            ST_FAULT: begin
                if (pll_if.fault_clr) begin
                    w_state_nxt = ST_PLL_RST;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_PLL_RST;
            end
        endcase
    end

    // The timer only counts in states with a terminal count; RUN and FAULT
    // hold it so it can never wrap.
    assign w_timer_run = (r_state == ST_PLL_RST) || (r_state == ST_WAIT_LOCK) ||
                         (r_state == ST_STABLE);

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= '0;
        end else if (w_timer_run) begin
            r_timer <= r_timer + TIMER_W'(1);
        end
    end

    // Outputs are decoded from the next state so they land on the same edge
    // as the state register.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_retry_cnt <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_lock_lost <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_retry_cnt <= w_retry_nxt;
            r_pll_rst   <= (w_state_nxt == ST_PLL_RST) || (w_state_nxt == ST_FAULT);
            r_sys_rst   <= (w_state_nxt != ST_RUN);
            r_lock_lost <= w_lock_lost_nxt;
            r_fault     <= (w_state_nxt == ST_FAULT);
        end
    end

    assign pll_if.pll_rst   = r_pll_rst;
    assign pll_if.sys_rst   = r_sys_rst;
    assign pll_if.lock_lost = r_lock_lost;
    assign pll_if.fault     = r_fault;
    assign pll_if.retry_cnt = r_retry_cnt;
    assign pll_if.state     = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with shortened timing parameters.
// Latency: expected edge numbers are derived arithmetically from the timing rules.
// Backpressure: n/a.
module tb_pll_lock_sequencer;

    localparam int P  = 4;
    localparam int T  = 20;
    localparam int S  = 8;
    localparam int M  = 2;
    localparam int HN = 4096;

    localparam int S_PRST = 0;
    localparam int S_WAIT = 1;
    localparam int S_STAB = 2;
    localparam int S_RUN  = 3;
    localparam int S_FLT  = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Per-edge history: index k holds the outputs right after clock edge k.
    logic [2:0] h_st   [HN];
    logic [1:0] h_rt   [HN];
    logic       h_prst [HN];
    logic       h_srst [HN];
    logic       h_ll   [HN];
    logic       h_flt  [HN];

    pll_lock_sequencer_if #(.MAX_RETRIES(M)) pif ();

    pll_lock_sequencer #(
        .PLL_RST_CYCLES (P),
        .LOCK_TIMEOUT   (T),
        .STABLE_CYCLES  (S),
        .MAX_RETRIES    (M)
    ) dut (
        .i_refclk (clk),
        .i_rst    (rst),
        .pll_if   (pif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (cyc < HN) begin
            h_st[cyc]   = pif.state;
            h_rt[cyc]   = pif.retry_cnt;
            h_prst[cyc] = pif.pll_rst;
            h_srst[cyc] = pif.sys_rst;
            h_ll[cyc]   = pif.lock_lost;
            h_flt[cyc]  = pif.fault;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    function automatic bit ok(input int k);
        return (k > 0) && (k < HN);
    endfunction
    function automatic int st(input int k);   return ok(k) ? int'(h_st[k])   : -1; endfunction
    function automatic int rt(input int k);   return ok(k) ? int'(h_rt[k])   : -1; endfunction
    function automatic int prst(input int k); return ok(k) ? int'(h_prst[k]) : -1; endfunction
    function automatic int srst(input int k); return ok(k) ? int'(h_srst[k]) : -1; endfunction
    function automatic int ll(input int k);   return ok(k) ? int'(h_ll[k])   : -1; endfunction
    function automatic int flt(input int k);  return ok(k) ? int'(h_flt[k])  : -1; endfunction

    function automatic int count_ll(input int a, input int b);
        int n;
        n = 0;
        for (int k = a; k <= b; k++) if (ll(k) != 0) n++;
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx, input int k);
        chk({pfx, "_state"},     st(k),   S_PRST);
        chk({pfx, "_pll_rst"},   prst(k), 1);
        chk({pfx, "_sys_rst"},   srst(k), 1);
        chk({pfx, "_lock_lost"}, ll(k),   0);
        chk({pfx, "_fault"},     flt(k),  0);
        chk({pfx, "_retry"},     rt(k),   0);
    endtask

    // In WAIT_LOCK with lock low: raise lock after 'delay' cycles; the first
    // sampling edge is c+1, STABLE follows two edges later, RUN after S more.
    task automatic lock_after(input string pfx, input int delay);
        int c;
        tick(delay);
        pif.pll_locked = 1'b1;
        c = cyc;
        tick(3 + S);
        chk({pfx, "_still_wait"}, st(c + 2),     S_WAIT);
        chk({pfx, "_stable"},     st(c + 3),     S_STAB);
        chk({pfx, "_sysrst_hi"},  srst(c + 2 + S), 1);
        chk({pfx, "_sysrst_lo"},  srst(c + 3 + S), 0);
        chk({pfx, "_run"},        st(c + 3 + S), S_RUN);
        chk({pfx, "_retry"},      rt(c + 3 + S), 0);
        chk({pfx, "_no_ll"},      count_ll(c, c + 3 + S), 0);
    endtask

    // In RUN: drop lock. Synchronized lock falls at c+2, reaction at c+3,
    // PLL reset held for P cycles, then WAIT_LOCK.
    task automatic lose_lock(input string pfx);
        int c;
        pif.pll_locked = 1'b0;
        c = cyc;
        tick(3 + P);
        chk({pfx, "_pre_sysrst"}, srst(c + 2), 0);
        chk({pfx, "_ll_early"},   ll(c + 2),   0);
        chk({pfx, "_ll_pulse"},   ll(c + 3),   1);
        chk({pfx, "_ll_clear"},   ll(c + 4),   0);
        chk({pfx, "_sysrst"},     srst(c + 3), 1);
        chk({pfx, "_pllrst"},     prst(c + 3), 1);
        chk({pfx, "_pllrst_end"}, prst(c + 2 + P), 1);
        chk({pfx, "_wait"},       st(c + 3 + P), S_WAIT);
        chk({pfx, "_pllrst_off"}, prst(c + 3 + P), 0);
        chk({pfx, "_retry"},      rt(c + 3 + P), 0);
    endtask

    // In WAIT_LOCK: lock rises, then drops for one cycle g cycles later.
    task automatic glitch(input string pfx, input int g);
        int c;
        pif.pll_locked = 1'b1;
        c = cyc;
        tick(g);
        pif.pll_locked = 1'b0;
        tick(1);
        pif.pll_locked = 1'b1;
        tick(3 + S);
        chk({pfx, "_stable"},    st(c + 3),         S_STAB);
        chk({pfx, "_back_wait"}, st(c + g + 3),     S_WAIT);
        chk({pfx, "_restable"},  st(c + g + 4),     S_STAB);
        chk({pfx, "_sysrst_hi"}, srst(c + g + 3 + S), 1);
        chk({pfx, "_sysrst_lo"}, srst(c + g + 4 + S), 0);
        chk({pfx, "_retry"},     rt(c + g + 4 + S), 0);
    endtask

    // In WAIT_LOCK with lock held low: M timeouts retry, the next one faults.
    task automatic never_lock(input string pfx, input bit hold);
        int w;
        int tk;
        int bad;
        w = cyc;
        tick(M * (T + P) + T);
        for (int k = 0; k <= M; k++) begin
            tk = w + k * (T + P) + T;
            chk({pfx, "_wait_before_to"}, st(tk - 1), S_WAIT);
            if (k < M) begin
                chk({pfx, "_to_pllrst"},  st(tk), S_PRST);
                chk({pfx, "_retry_pre"},  rt(tk - 1), k);
                chk({pfx, "_retry_post"}, rt(tk), k + 1);
            end else begin
                chk({pfx, "_fault_state"}, st(tk),   S_FLT);
                chk({pfx, "_fault_pre"},   flt(tk - 1), 0);
                chk({pfx, "_fault"},       flt(tk),  1);
                chk({pfx, "_fault_pll"},   prst(tk), 1);
                chk({pfx, "_fault_sys"},   srst(tk), 1);
                chk({pfx, "_fault_retry"}, rt(tk),   M);
            end
        end
        if (hold) begin
            tk = cyc;
            for (int i = 0; i < 1000; i++) begin
                pif.pll_locked = 1'($urandom_range(0, 1));
                tick(1);
            end
            pif.pll_locked = 1'b1;
            tick(2);
            bad = 0;
            for (int k = tk + 1; k <= cyc; k++) begin
                if (st(k) != S_FLT || flt(k) != 1 || prst(k) != 1 || srst(k) != 1) bad++;
            end
            chk({pfx, "_held_cycles_off"}, bad, 0);
        end
    endtask

    initial begin
        int c;
        int r;
        int bad;

        rst            = 1'b1;
        pif.pll_locked = 1'b0;
        pif.fault_clr  = 1'b0;
        tick(3);
        chk_reset("rst", cyc);

        // Bring-up: PLL reset held for exactly P edges, lock 5 cycles after it falls.
        rst = 1'b0;
        r   = cyc;
        tick(P);
        chk("bring_pllrst_last", st(r + P - 1), S_PRST);
        chk("bring_pllrst_hi",   prst(r + P - 1), 1);
        chk("bring_wait",        st(r + P), S_WAIT);
        chk("bring_pllrst_lo",   prst(r + P), 0);
        lock_after("bring", 5);

        // Loss in RUN after a random dwell, then re-lock.
        c = cyc;
        tick($urandom_range(1, 30));
        bad = 0;
        for (int k = c; k <= cyc; k++) if (srst(k) != 0) bad++;
        chk("run_dwell_sysrst", bad, 0);
        lose_lock("loss1");
        lock_after("relock1", $urandom_range(0, 12));

        // Glitch during STABLE: once at timer=5, once at a random point.
        lose_lock("loss2");
        glitch("glitch_t5", 6);
        lose_lock("loss3");
        glitch("glitch_rnd", $urandom_range(1, 8));

        // Never locks: retries, then sticky FAULT regardless of pll_locked.
        lose_lock("loss4");
        never_lock("nolock", 1'b1);

        // Fault clear with lock already present.
        pif.fault_clr = 1'b1;
        c = cyc;
        tick(1);
        pif.fault_clr = 1'b0;
        tick(P + 1 + S);
        chk("fclr_pre_fault",  st(c), S_FLT);
        chk("fclr_state",      st(c + 1), S_PRST);
        chk("fclr_fault",      flt(c + 1), 0);
        chk("fclr_retry",      rt(c + 1), 0);
        chk("fclr_pllrst",     prst(c + 1), 1);
        chk("fclr_pllrst_end", st(c + P), S_PRST);
        chk("fclr_wait",       st(c + 1 + P), S_WAIT);
        chk("fclr_stable",     st(c + 2 + P), S_STAB);
        chk("fclr_sysrst_hi",  srst(c + 1 + P + S), 1);
        chk("fclr_sysrst_lo",  srst(c + 2 + P + S), 0);

        // Reset and fault_clr together: reset wins and is held three edges.
        lose_lock("loss5");
        never_lock("nolock2", 1'b0);
        rst           = 1'b1;
        pif.fault_clr = 1'b1;
        c = cyc;
        tick(1);
        pif.fault_clr = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(P);
        chk_reset("rst_fclr", c + 1);
        chk("rst_fclr_held",   st(c + 1 + P), S_PRST);
        chk("rst_fclr_prst",   st(c + 2 + P), S_PRST);
        chk("rst_fclr_wait",   st(c + 3 + P), S_WAIT);
        lock_after("rst_fclr_lock", $urandom_range(0, 12));

        // Reset at STABLE timer=3: outputs to reset values, sequence restarts.
        lose_lock("loss6");
        pif.pll_locked = 1'b1;
        c = cyc;
        tick(6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(P + 1 + S);
        chk("stabrst_was_stable", st(c + 6), S_STAB);
        chk_reset("stabrst", c + 7);
        chk("stabrst_prst",      st(c + 6 + P), S_PRST);
        chk("stabrst_wait",      st(c + 7 + P), S_WAIT);
        chk("stabrst_stable",    st(c + 8 + P), S_STAB);
        chk("stabrst_sysrst_hi", srst(c + 7 + P + S), 1);
        chk("stabrst_sysrst_lo", srst(c + 8 + P + S), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
